// File: rtl/muldiv_unit_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_unit_pkg
// Shared definitions for the execute stage: ALU operation codes (including the
// multiply/divide codes served by the iterative unit), the multiply/divide FSM
// state type and the default datapath width.
// -----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int MULDIV_WIDTH = 32;

    // Execute-stage ALU operation codes
    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
    localparam logic [3:0] ALU_OP_AND  = 4'b0010;
    localparam logic [3:0] ALU_OP_OR   = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0110;
    localparam logic [3:0] ALU_OP_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OP_SLT  = 4'b1000;
    localparam logic [3:0] ALU_OP_SLTU = 4'b1001;
    localparam logic [3:0] ALU_OP_MUL  = 4'b1100;
    localparam logic [3:0] ALU_OP_DIV  = 4'b1101;
    localparam logic [3:0] ALU_OP_REM  = 4'b1110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } muldiv_state_t;

    // True for the op codes the iterative unit executes
    function automatic logic is_muldiv_op(input logic [3:0] op);
        logic hit;
        case (op)
            ALU_OP_MUL: hit = 1'b1;
            ALU_OP_DIV: hit = 1'b1;
            ALU_OP_REM: hit = 1'b1;
            default:    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One iteration of the multiply/divide datapath, purely combinational.
//   is_div  : 0 = shift-add multiply step, 1 = restoring-divide step
//   hi, lo  : current working pair (mul: partial product high / multiplier,
//             div: partial remainder / dividend-becoming-quotient)
//   b       : multiplicand (mul) or divisor (div)
//   hi_next, lo_next : working pair after this iteration
// -----------------------------------------------------------------------------
module muldiv_step
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // Single iteration: add-then-shift-right for multiply, shift-left-then-
    // trial-subtract for divide
    always_comb begin
        sum_s     = '0;
        shifted_s = '0;
        diff_s    = '0;
        ge_s      = 1'b0;
        hi_next   = hi;
        lo_next   = lo;
        if (is_div) begin
            shifted_s = {hi, lo[WIDTH-1]};
            ge_s      = (shifted_s >= {1'b0, b});
            // When the trial subtract succeeds the difference is below b, so
            // the narrow subtraction is exact
            diff_s    = shifted_s[WIDTH-1:0] - b;
            if (ge_s) begin
                hi_next = diff_s;
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted_s[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (lo[0]) begin
                sum_s = {1'b0, hi} + {1'b0, b};
            end else begin
                sum_s = {1'b0, hi};
            end
            // Carry enters the high half; the bit shifted out of the high half
            // enters the top of the low half, displacing the consumed multiplier bit
            hi_next = sum_s[WIDTH:1];
            lo_next = {sum_s[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative unsigned multiply / divide / remainder for the execute stage.
// WIDTH iterations per operation; result and flags feed the result mux.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : request; accepted in IDLE or DONE with a mul/div/rem code
//   cu_aluOp     : 1100 multiply, 1101 quotient, 1110 remainder
//   data1, data2 : operand A (multiplicand/dividend), B (multiplier/divisor)
//   busy         : high while iterating
//   done         : one-cycle pulse when result becomes valid
//   result       : registered result, held until overwritten
//   zero         : result == 0
//   negative     : result MSB
//   divByZero    : divide/remainder ran with a zero divisor
// -----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cu_aluOp,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             divByZero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    muldiv_state_t    state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             op_div_r;
    logic             op_rem_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] result_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;

    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] hi_next_s;
    logic [WIDTH-1:0] lo_next_s;

    muldiv_step #(
        .WIDTH   (WIDTH)
    ) u_step (
        .is_div  (op_div_r),
        .hi      (hi_r),
        .lo      (lo_r),
        .b       (b_r),
        .hi_next (hi_next_s),
        .lo_next (lo_next_s)
    );

    // Start acceptance and final-iteration detection
    always_comb begin
        accept_s = start && (state_r != RUN) && is_muldiv_op(cu_aluOp);
        last_s   = (state_r == RUN) && (cnt_r == CNT_LAST);
    end

    // Control FSM, iteration counter, working registers and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            op_div_r <= 1'b0;
            op_rem_r <= 1'b0;
            hi_r     <= '0;
            lo_r     <= '0;
            b_r      <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        state_r  <= RUN;
                        cnt_r    <= '0;
                        op_div_r <= (cu_aluOp != ALU_OP_MUL);
                        op_rem_r <= (cu_aluOp == ALU_OP_REM);
                        hi_r     <= '0;
                        // Multiply walks the multiplier through lo; divide
                        // walks the dividend through lo
                        if (cu_aluOp == ALU_OP_MUL) begin
                            lo_r <= data2;
                            b_r  <= data1;
                        end else begin
                            lo_r <= data1;
                            b_r  <= data2;
                        end
                        busy_r   <= 1'b1;
                        dbz_r    <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                RUN: begin
                    hi_r  <= hi_next_s;
                    lo_r  <= lo_next_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        result_r <= op_rem_r ? hi_next_s : lo_next_s;
                        dbz_r    <= op_div_r && (b_r == '0);
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= DONE;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Outputs; flags derive from the result register only
    assign busy      = busy_r;
    assign done      = done_r;
    assign result    = result_r;
    assign divByZero = dbz_r;
    assign zero      = (result_r == '0);
    assign negative  = result_r[WIDTH-1];

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: the driver pushes the expected outcome of
// every accepted operation; a monitor pops and compares on each done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b1100;
    localparam logic [3:0] OP_DIV = 4'b1101;
    localparam logic [3:0] OP_REM = 4'b1110;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   cu_aluOp;
    logic [W-1:0] data1;
    logic [W-1:0] data2;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         divByZero;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .cu_aluOp  (cu_aluOp),
        .data1     (data1),
        .data2     (data2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .divByZero (divByZero)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // Reference: plain unsigned arithmetic
    function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (op)
            OP_MUL:  return p[W-1:0];
            OP_DIV:  return (b == '0) ? '1 : a / b;
            OP_REM:  return (b == '0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    // Monitor: compare every done pulse against the oldest expectation
    always @(negedge clock) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check_bit("zero", zero, (e.res == '0));
                check_bit("negative", negative, e.res[W-1]);
                check_bit("divByZero", divByZero, e.dbz);
                check("done_cycle", cyc, e.due);
                check_bit("busy_with_done", busy, 1'b0);
            end
        end
    end

    // Drive an accepted start (called just after a falling edge)
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        start    = 1'b1;
        cu_aluOp = op;
        data1    = a;
        data2    = b;
        @(posedge clock);
        #1;
        start = 1'b0;
        data1 = $urandom;
        data2 = $urandom;
        e.res = model(op, a, b);
        e.dbz = (op != OP_MUL) && (b == '0);
        e.due = cyc + W;
        exp_q.push_back(e);
        check_bit("busy_after_start", busy, 1'b1);
        check_bit("dbz_clear_on_start", divByZero, 1'b0);
    endtask

    // Wait (bounded) for the done pulse; returns at that falling edge
    task automatic wait_done(output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, expected done", W + 8);
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;

        reset    = 1'b1;
        start    = 1'b0;
        cu_aluOp = 4'b0000;
        data1    = '0;
        data2    = '0;
        repeat (2) @(negedge clock);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check("rst_result", result, 32'd0);
        check_bit("rst_zero", zero, 1'b1);
        check_bit("rst_negative", negative, 1'b0);
        check_bit("rst_dbz", divByZero, 1'b0);
        reset = 1'b0;

        // 7 * 6, with busy-cycle count
        @(negedge clock);
        issue(OP_MUL, 32'd7, 32'd6);
        wait_done(n);
        check("busy_cycles", n, 32'd32);

        // Multiply boundaries
        @(negedge clock);
        issue(OP_MUL, 32'hFFFF_FFFF, 32'd2);
        wait_done(n);
        @(negedge clock);
        issue(OP_MUL, $urandom, 32'd0);
        wait_done(n);

        // Divide then remainder, second start in the DONE cycle
        @(negedge clock);
        issue(OP_DIV, 32'd100, 32'd7);
        wait_done(n);
        issue(OP_REM, 32'd100, 32'd7);
        wait_done(n);

        // Divide by zero, then a clearing op
        @(negedge clock);
        issue(OP_DIV, 32'h0000_1234, 32'd0);
        wait_done(n);
        @(negedge clock);
        issue(OP_REM, 32'h0000_1234, 32'd0);
        wait_done(n);
        @(negedge clock);
        issue(OP_MUL, 32'd3, 32'd5);
        wait_done(n);

        // Start during RUN is ignored
        @(negedge clock);
        issue(OP_MUL, 32'd7, 32'd6);
        repeat (5) @(negedge clock);
        start    = 1'b1;
        cu_aluOp = OP_DIV;
        data1    = 32'd100;
        data2    = 32'd7;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_bit("busy_run_ignore", busy, 1'b1);
        wait_done(n);

        // Non-muldiv opcode in IDLE is ignored
        @(negedge clock);
        start    = 1'b1;
        cu_aluOp = 4'b0001;
        data1    = 32'd9;
        data2    = 32'd9;
        @(posedge clock);
        #1;
        start = 1'b0;
        check_bit("busy_bad_op", busy, 1'b0);
        repeat (3) @(negedge clock);
        check_bit("busy_bad_op_later", busy, 1'b0);
        check("result_held", result, 32'd42);

        // Reset in cycle 10 of a divide
        @(negedge clock);
        issue(OP_DIV, $urandom, 32'd13);
        repeat (9) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check("midrst_result", result, 32'd0);
        check_bit("midrst_zero", zero, 1'b1);
        check_bit("midrst_negative", negative, 1'b0);
        check_bit("midrst_dbz", divByZero, 1'b0);
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (W + 4) @(negedge clock);
        check_bit("no_done_after_abort", busy, 1'b0);
        issue(OP_MUL, 32'd7, 32'd6);
        wait_done(n);

        // Randomized ops, random gaps including back-to-back
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0:       op = OP_MUL;
                1:       op = OP_DIV;
                default: op = OP_REM;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clock);
            issue(op, a, b);
            wait_done(n);
        end

        repeat (3) @(negedge clock);
        check("queue_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
